// File: rtl/truth_table_checker.sv
// On-board BIST sequencer: walks every input vector of a small combinational
// block, samples its output after a settle interval and scores it against a golden table.
module truth_table_checker #(
    parameter int                   N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 16'hE8E8,
    parameter int                   SETTLE   = 2
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iStart,
    input  logic            iY,
    output logic [N_IN-1:0] oVec,
    output logic            oBusy,
    output logic            oDone,
    output logic            oPass,
    output logic [N_IN:0]   oErrCnt,
    output logic [N_IN-1:0] oFirstFail,
    output logic            oFirstValid
);

    localparam int NV    = 1 << N_IN;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(NV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             start_run;
    logic             sample;
    logic             last_vec;
    logic             mismatch;

    // iStart is only honoured outside a run; there is no abort path.
    assign start_run = iStart && ((state == IDLE) || (state == DONE));
    assign sample    = (state == DRIVE) && (cnt == CNT_LAST);
    assign last_vec  = (oVec == LAST_VEC);
    assign mismatch  = sample && (iY != EXPECTED[oVec]);

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (iStart) state_nxt = DRIVE;
            DRIVE:   if (sample && last_vec) state_nxt = DONE;
            DONE:    if (iStart) state_nxt = DRIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        oPass = oDone && (oErrCnt == '0);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oVec        <= '0;
            cnt         <= '0;
            oErrCnt     <= '0;
            oFirstFail  <= '0;
            oFirstValid <= 1'b0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
        end else if (start_run) begin
            oVec        <= '0;
            cnt         <= '0;
            oErrCnt     <= '0;
            oFirstFail  <= '0;
            oFirstValid <= 1'b0;
            oBusy       <= 1'b1;
            oDone       <= 1'b0;
        end else if (state == DRIVE) begin
            if (sample) begin
                if (mismatch) begin
                    oErrCnt <= oErrCnt + (N_IN+1)'(1);
                    if (!oFirstValid) begin
                        oFirstFail  <= oVec;
                        oFirstValid <= 1'b1;
                    end
                end
                // The last vector stays on the bus after the run finishes.
                if (last_vec) begin
                    oBusy <= 1'b0;
                    oDone <= 1'b1;
                end else begin
                    oVec <= oVec + N_IN'(1);
                    cnt  <= '0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench for truth_table_checker: a behavioural logic block with
// injectable faults answers each vector; expected run results are queued at start.
module tb_truth_table_checker;

    localparam int              N  = 4;
    localparam int              S  = 2;
    localparam int              NV = 16;
    localparam logic [NV-1:0]   TT = 16'hE8E8;

    typedef struct {
        logic [N:0]   err;
        logic [N-1:0] ff;
        logic         fv;
        logic         pass;
    } res_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic          y;
    logic [N-1:0]  vec;
    logic          busy;
    logic          done;
    logic          pass;
    logic [N:0]    err_cnt;
    logic [N-1:0]  first_fail;
    logic          first_valid;
    logic [NV-1:0] fault;

    res_t sb[$];
    int   n_checks;
    int   n_fail;

    truth_table_checker #(.N_IN(N), .EXPECTED(TT), .SETTLE(S)) dut (
        .iClk        (clk),
        .iRst        (rst),
        .iStart      (start),
        .iY          (y),
        .oVec        (vec),
        .oBusy       (busy),
        .oDone       (done),
        .oPass       (pass),
        .oErrCnt     (err_cnt),
        .oFirstFail  (first_fail),
        .oFirstValid (first_valid)
    );

    // Behavioural logic under test: golden table with per-vector fault injection.
    always_comb y = TT[vec] ^ fault[vec];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vec"}, 32'(vec), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err_cnt), 32'd0);
        check({tag, "_fv"}, 32'(first_valid), 32'd0);
        check({tag, "_ff"}, 32'(first_fail), 32'd0);
    endtask

    task automatic push_expected(input logic [NV-1:0] f);
        res_t r;
        r.err  = (N+1)'($countones(f));
        r.fv   = (f != '0);
        r.pass = (f == '0);
        r.ff   = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (f[i]) r.ff = N'(i);
        end
        sb.push_back(r);
    endtask

    task automatic run(input logic [NV-1:0] f, input bit hold);
        res_t r;
        int   w;
        fault = f;
        push_expected(f);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < S * NV; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (k == 0) begin
                check("clr_err", 32'(err_cnt), 32'd0);
                check("clr_fv", 32'(first_valid), 32'd0);
                check("clr_done", 32'(done), 32'd0);
            end
            if (vec !== N'(k / S)) check("vec_step", 32'(vec), 32'(k / S));
            if (busy !== 1'b1) check("busy_run", 32'(busy), 32'd1);
            if (done !== 1'b0) check("done_run", 32'(done), 32'd0);
        end
        w = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("done_rise", 32'(done), 32'd1);
        check("run_len_extra", 32'(w), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("vec_hold", 32'(vec), 32'(NV - 1));
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            r = sb.pop_front();
            check("err_cnt", 32'(err_cnt), 32'(r.err));
            check("first_valid", 32'(first_valid), 32'(r.fv));
            check("pass", 32'(pass), 32'(r.pass));
            if (r.fv) check("first_fail", 32'(first_fail), 32'(r.ff));
        end
        repeat (3) @(negedge clk);
        check("done_stable", 32'(done), 32'd1);
        check("err_stable", 32'(err_cnt), 32'(r.err));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fault    = '0;
        start    = 1'b0;
        rst      = 1'b1;
        #1;
        check_idle("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (vec !== '0 || busy || done || err_cnt !== '0 || first_valid)
                check("idle_hold", {vec, busy, done, err_cnt, first_valid}, 32'd0);
        end
        check_idle("idle_end");

        run(16'h0000, 1'b0);
        run(16'h1020, 1'b1);
        run(16'h0000, 1'b0);
        run(16'hFFFF, 1'b0);
        check("stuck_err_w", 32'(err_cnt), 32'h10);

        // Asynchronous reset landing between edges in the middle of a run.
        fault = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("post_rst");

        run(16'h0001, 1'b0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
